// File: rtl/stereo_pkg.sv
// Shared types and sizing helper for the stereo streaming shell.
package stereo_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef struct packed {
        logic valid;
        logic eol;
        logic eof;
        logic mask;
    } tag_t;

    // Index width for a range of n values, never less than one bit.
    function automatic int disp_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stereo_stream_if.sv
// Pixel-in / disparity-out stream bundle plus the core-facing pins.
// slave is the shell side; master is the producer/consumer/core side.
interface stereo_stream_if
    import stereo_pkg::*;
#(
    parameter int DW   = 8,
    parameter int DISP = 80,
    parameter int OW   = 8
);
    localparam int DISPW = disp_w(DISP);

    logic             enq_l;
    logic [DW-1:0]    din_l;
    logic             full_n_l;
    logic             enq_r;
    logic [DW-1:0]    din_r;
    logic             full_n_r;
    logic             out_deq;
    logic             out_empty_n;
    logic [OW-1:0]    dout;
    logic             dout_eol;
    logic             dout_eof;
    logic             core_en;
    logic [DW-1:0]    core_l;
    logic [DW-1:0]    core_r;
    logic [DISPW-1:0] core_disp;
    logic [15:0]      frame_cnt;

    modport slave (
        input  enq_l, din_l, enq_r, din_r, out_deq, core_disp,
        output full_n_l, full_n_r, out_empty_n, dout, dout_eol, dout_eof,
               core_en, core_l, core_r, frame_cnt
    );

    modport master (
        output enq_l, din_l, enq_r, din_r, out_deq, core_disp,
        input  full_n_l, full_n_r, out_empty_n, dout, dout_eol, dout_eof,
               core_en, core_l, core_r, frame_cnt
    );

endinterface

// File: rtl/stereo_sync_fifo.sv
// Synchronous FIFO, registered occupancy, head visible the cycle after a write.
// Latency 1; enq ignored while full, deq ignored while empty; head reads 0 when empty.
module stereo_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         enq_i,
    input  logic [W-1:0] din_i,
    output logic         full_n_o,
    input  logic         deq_i,
    output logic [W-1:0] dout_o,
    output logic         empty_n_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          wr_acc;
    logic          rd_acc;

    assign full_n_o  = (cnt_q != (AW+1)'(DEPTH));
    assign empty_n_o = (cnt_q != '0);
    assign wr_acc    = enq_i && full_n_o;
    assign rd_acc    = deq_i && empty_n_o;
    assign dout_o    = empty_n_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (wr_acc && !rd_acc)      cnt_q <= cnt_q + (AW+1)'(1);
            else if (rd_acc && !wr_acc) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !clr_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/stereo_stream_top.sv
// Census/argmin shell: L/R FIFOs feed the core in lockstep, tagged results go to an output FIFO.
// Result lands CORE_LAT enabled cycles after its pair; full output FIFO freezes core and tags.
module stereo_stream_top
    import stereo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int DISP     = 80,
    parameter int OW       = 8,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int CORE_LAT = 4,
    parameter int DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    stereo_stream_if.slave  bus
);
    localparam int DISPW = disp_w(DISP);
    localparam int CW    = disp_w(IMG_W);
    localparam int RW    = disp_w(IMG_H);
    localparam int DCW   = disp_w(CORE_LAT + 1);

    logic [DW-1:0]   l_head, r_head;
    logic            l_empty_n, r_empty_n;
    logic            o_full_n, o_enq;
    logic [OW+1:0]   o_din, o_head;
    logic [DISPW-1:0] disp_in;
    logic [OW-1:0]   disp_ext;

    state_t          state_q;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [DCW-1:0]  drain_q;
    logic [15:0]     frame_q;
    tag_t            tag_q [CORE_LAT];

    logic            fire_run, fire_bub, adv;
    logic            col_last, row_last;
    tag_t            tag_in, tag_out;

    stereo_sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo_l (
        .clk(clk), .rst_n(rst_n), .clr_i(clr),
        .enq_i(bus.enq_l), .din_i(bus.din_l), .full_n_o(bus.full_n_l),
        .deq_i(fire_run), .dout_o(l_head), .empty_n_o(l_empty_n)
    );

    stereo_sync_fifo #(.W(DW), .DEPTH(DEPTH)) u_fifo_r (
        .clk(clk), .rst_n(rst_n), .clr_i(clr),
        .enq_i(bus.enq_r), .din_i(bus.din_r), .full_n_o(bus.full_n_r),
        .deq_i(fire_run), .dout_o(r_head), .empty_n_o(r_empty_n)
    );

    stereo_sync_fifo #(.W(OW + 2), .DEPTH(DEPTH)) u_fifo_o (
        .clk(clk), .rst_n(rst_n), .clr_i(clr),
        .enq_i(o_enq), .din_i(o_din), .full_n_o(o_full_n),
        .deq_i(bus.out_deq), .dout_o(o_head), .empty_n_o(bus.out_empty_n)
    );

    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign tag_out  = tag_q[CORE_LAT-1];
    assign disp_in  = bus.core_disp;
    assign disp_ext = OW'(disp_in);

    always_comb begin
        fire_run = (state_q == RUN) && l_empty_n && r_empty_n && o_full_n && !clr;
        fire_bub = (state_q == DRAIN) && o_full_n && !clr;
        adv      = fire_run || fire_bub;
        tag_in   = '0;
        if (fire_run) begin
            tag_in.valid = 1'b1;
            tag_in.eol   = col_last;
            tag_in.eof   = col_last && row_last;
            tag_in.mask  = (int'(col_q) < DISP - 1);
        end
        o_enq = adv && tag_out.valid;
        o_din = {tag_out.eof, tag_out.eol, tag_out.mask ? '0 : disp_ext};
    end

    assign bus.core_en   = adv;
    assign bus.core_l    = fire_run ? l_head : '0;
    assign bus.core_r    = fire_run ? r_head : '0;
    assign bus.dout      = o_head[OW-1:0];
    assign bus.dout_eol  = o_head[OW];
    assign bus.dout_eof  = o_head[OW+1];
    assign bus.frame_cnt = frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            frame_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= '0;
        end else if (clr) begin
            state_q <= RUN;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            frame_q <= '0;
            for (int i = 0; i < CORE_LAT; i++) tag_q[i] <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (fire_run && tag_in.eof) begin
                        state_q <= DRAIN;
                        drain_q <= DCW'(CORE_LAT);
                    end
                end
                DRAIN: begin
                    // Bubbles push the in-flight tail of the frame out of the core.
                    if (fire_bub) begin
                        drain_q <= drain_q - DCW'(1);
                        if (drain_q == DCW'(1)) state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase

            if (fire_run) begin
                if (col_last) begin
                    col_q <= '0;
                    row_q <= row_last ? '0 : row_q + RW'(1);
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end

            if (adv) begin
                tag_q[0] <= tag_in;
                for (int i = 1; i < CORE_LAT; i++) tag_q[i] <= tag_q[i-1];
            end

            if (o_enq && tag_out.eof) frame_q <= frame_q + 16'd1;
        end
    end

endmodule
